// File: rtl/hamming_secded_enc_pipe.sv
// Pipelined Hamming encoder (SECDED or SEC-only) with valid/ready on both sides,
// one-shot error injection for decoder testing and a delivered-word counter.
module hamming_secded_enc_pipe #(
    parameter int  DATA_W = 16,
    parameter int  SECDED = 1,
    parameter int  PIPE   = 2,
    localparam int R      = (DATA_W + 3 <= 4)  ? 2 :
                            (DATA_W + 4 <= 8)  ? 3 :
                            (DATA_W + 5 <= 16) ? 4 :
                            (DATA_W + 6 <= 32) ? 5 :
                            (DATA_W + 7 <= 64) ? 6 : 7,
    localparam int CODE_W = DATA_W + R + SECDED,
    localparam int POS_W  = $clog2(CODE_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] data_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] code_out,
    input  logic              inj_req,
    input  logic [POS_W-1:0]  inj_pos,
    input  logic              inj_double,
    output logic              inj_armed,
    output logic [15:0]       word_cnt
);

    localparam int N = DATA_W + R;

    // Hamming positions 1..N; parity at powers of two, data fills the rest in order.
    function automatic logic [CODE_W-1:0] encode(input logic [DATA_W-1:0] d);
        logic [N:0]        h;
        logic [CODE_W-1:0] c;
        logic              par;
        int                j;
        h = '0;
        c = '0;
        j = 0;
        for (int p = 1; p <= N; p++) begin
            if ((p & (p - 1)) != 0) begin
                h[p] = d[j];
                j++;
            end
        end
        for (int i = 0; i < R; i++) begin
            par = 1'b0;
            for (int p = 1; p <= N; p++) begin
                if (p[i]) par = par ^ h[p];
            end
            h[2**i] = par;
        end
        for (int p = 1; p <= N; p++) c[p - 1 + SECDED] = h[p];
        if (SECDED != 0) c[0] = ^h;
        return c;
    endfunction

    // Out-of-range positions produce an empty mask; the double flip wraps to bit 0.
    function automatic logic [CODE_W-1:0] flip_mask(input logic [POS_W-1:0] pos,
                                                    input logic dbl);
        logic [CODE_W-1:0] m;
        int                p;
        int                q;
        m = '0;
        p = int'(pos);
        if (p < CODE_W) begin
            m = {{(CODE_W-1){1'b0}}, 1'b1} << p;
            q = (p == CODE_W - 1) ? 0 : p + 1;
            if (dbl) m = m | ({{(CODE_W-1){1'b0}}, 1'b1} << q);
        end
        return m;
    endfunction

    logic              s1_valid_q, s1_valid_d;
    logic [DATA_W-1:0] s1_data_q, s1_data_d;
    logic [CODE_W-1:0] s1_mask_q, s1_mask_d;
    logic              inj_armed_q, inj_armed_d;
    logic [POS_W-1:0]  inj_pos_q, inj_pos_d;
    logic              inj_dbl_q, inj_dbl_d;
    logic [15:0]       word_cnt_q, word_cnt_d;

    logic              s1_adv;
    logic              accept;
    logic              out_fire;
    logic              inj_apply;
    logic [POS_W-1:0]  inj_sel_pos;
    logic              inj_sel_dbl;
    logic [CODE_W-1:0] s1_code;

    // Handshake: a word moves across an interface on a rising edge where valid and
    // ready are both high; a held valid keeps its payload stable until taken, and
    // ready may depend combinationally on downstream ready so bubbles collapse.
    assign in_ready  = rst_n && en && (!s1_valid_q || s1_adv);
    assign accept    = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign s1_code   = encode(s1_data_q) ^ s1_mask_q;
    assign inj_armed = inj_armed_q;
    assign word_cnt  = word_cnt_q;

    // A pending injection wins over a coincident request, which then re-arms.
    always_comb begin
        inj_apply   = inj_armed_q || inj_req;
        inj_sel_pos = inj_armed_q ? inj_pos_q : inj_pos;
        inj_sel_dbl = inj_armed_q ? inj_dbl_q : inj_double;
        inj_armed_d = inj_armed_q;
        inj_pos_d   = inj_pos_q;
        inj_dbl_d   = inj_dbl_q;
        if (inj_req && !(accept && !inj_armed_q)) begin
            inj_armed_d = 1'b1;
            inj_pos_d   = inj_pos;
            inj_dbl_d   = inj_double;
        end else if (accept) begin
            inj_armed_d = 1'b0;
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_mask_d  = s1_mask_q;
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_data_d  = data_in;
            s1_mask_d  = inj_apply ? flip_mask(inj_sel_pos, inj_sel_dbl) : '0;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end
    end

    always_comb begin
        word_cnt_d = word_cnt_q + 16'(out_fire);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s1_mask_q   <= '0;
            inj_armed_q <= 1'b0;
            inj_pos_q   <= '0;
            inj_dbl_q   <= 1'b0;
            word_cnt_q  <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            s1_mask_q   <= s1_mask_d;
            inj_armed_q <= inj_armed_d;
            inj_pos_q   <= inj_pos_d;
            inj_dbl_q   <= inj_dbl_d;
            word_cnt_q  <= word_cnt_d;
        end
    end

    if (PIPE == 1) begin : g_pipe1
        assign s1_adv    = s1_valid_q && out_ready;
        assign out_valid = s1_valid_q;
        assign code_out  = s1_code;
    end else begin : g_pipe2
        logic              s2_valid_q, s2_valid_d;
        logic [CODE_W-1:0] s2_code_q, s2_code_d;

        assign s1_adv    = s1_valid_q && (!s2_valid_q || out_ready);
        assign out_valid = s2_valid_q;
        assign code_out  = s2_code_q;

        always_comb begin
            s2_valid_d = s2_valid_q;
            s2_code_d  = s2_code_q;
            if (s1_adv) begin
                s2_valid_d = 1'b1;
                s2_code_d  = s1_code;
            end else if (out_ready) begin
                s2_valid_d = 1'b0;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s2_valid_q <= 1'b0;
                s2_code_q  <= '0;
            end else begin
                s2_valid_q <= s2_valid_d;
                s2_code_q  <= s2_code_d;
            end
        end
    end

endmodule

// File: tb/tb_hamming_secded_enc_pipe.sv
// Bench for hamming_secded_enc_pipe: directed DATA_W=4 cases plus a random
// DATA_W=16 stream, both scored against an expected-codeword queue.
module tb_hamming_secded_enc_pipe;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        a_en, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [3:0]  a_data;
    logic [7:0]  a_code;
    logic        a_inj_req, a_inj_dbl, a_inj_armed;
    logic [2:0]  a_inj_pos;
    logic [15:0] a_word_cnt;

    logic        b_en, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [15:0] b_data;
    logic [21:0] b_code;
    logic        b_inj_req, b_inj_dbl, b_inj_armed;
    logic [4:0]  b_inj_pos;
    logic [15:0] b_word_cnt;

    hamming_secded_enc_pipe #(.DATA_W(4), .SECDED(1), .PIPE(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(a_en), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .data_in(a_data), .out_valid(a_out_valid), .out_ready(a_out_ready), .code_out(a_code),
        .inj_req(a_inj_req), .inj_pos(a_inj_pos), .inj_double(a_inj_dbl),
        .inj_armed(a_inj_armed), .word_cnt(a_word_cnt)
    );

    hamming_secded_enc_pipe #(.DATA_W(16), .SECDED(1), .PIPE(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(b_en), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .data_in(b_data), .out_valid(b_out_valid), .out_ready(b_out_ready), .code_out(b_code),
        .inj_req(b_inj_req), .inj_pos(b_inj_pos), .inj_double(b_inj_dbl),
        .inj_armed(b_inj_armed), .word_cnt(b_word_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference encoder: parity bits are chosen so the XOR of all set positions is zero.
    function automatic logic [63:0] ref_code(input int dw, input logic [63:0] d);
        logic [63:0] w;
        int          r, j, syn;
        r = 2;
        while ((1 << r) < dw + r + 1) r++;
        w   = '0;
        j   = 0;
        syn = 0;
        for (int p = 1; p <= dw + r; p++) begin
            if ((p & (p - 1)) != 0) begin
                w[p] = d[j];
                if (d[j]) syn = syn ^ p;
                j++;
            end
        end
        for (int i = 0; i < r; i++) w[1 << i] = syn[i];
        w[0] = ^w;
        return w;
    endfunction

    function automatic logic [63:0] flip_msk(input int cw, input int p, input logic dbl);
        logic [63:0] m;
        m = '0;
        if (p < cw) begin
            m[p] = 1'b1;
            if (dbl) m[(p + 1) % cw] = 1'b1;
        end
        return m;
    endfunction

    logic [63:0] exp_q0[$];
    logic [63:0] exp_q1[$];
    int          syn_q1[$];
    bit          m_armed[2];
    int          m_pos[2];
    bit          m_dbl[2];
    int          m_cnt[2];
    bit          stall_v[2];
    logic [63:0] stall_c[2];
    bit          acc_f[2];
    int          pushed[2];

    // Per-cycle model step for one instance, evaluated at the falling edge.
    task automatic mon(input int id, input int cw, input int dw, input logic ov,
                       input logic ordy, input logic [63:0] code, input logic iv,
                       input logic ir, input logic en_i, input logic [63:0] data,
                       input logic ireq, input int ipos, input logic idbl,
                       input logic armed, input logic [15:0] cnt);
        logic [63:0] e;
        int          syn, es, qs, p;
        logic        d, acc;
        string       px;
        px = (id == 0) ? "a" : "b";
        acc_f[id] = 1'b0;
        if (!rst_n) begin
            check({px, "_rst_out_valid"}, 64'(ov), 64'(0));
            check({px, "_rst_in_ready"}, 64'(ir), 64'(0));
            check({px, "_rst_armed"}, 64'(armed), 64'(0));
            check({px, "_rst_word_cnt"}, 64'(cnt), 64'(0));
            if (id == 0) exp_q0.delete();
            else begin
                exp_q1.delete();
                syn_q1.delete();
            end
            m_armed[id] = 1'b0;
            m_cnt[id]   = 0;
            stall_v[id] = 1'b0;
            return;
        end
        if (stall_v[id]) begin
            check({px, "_hold_valid"}, 64'(ov), 64'(1));
            check({px, "_hold_code"}, code, stall_c[id]);
        end
        stall_v[id] = ov && !ordy;
        stall_c[id] = code;
        check({px, "_armed"}, 64'(armed), 64'(m_armed[id]));
        check({px, "_word_cnt"}, 64'(cnt), 64'(m_cnt[id]));
        if (!en_i) check({px, "_in_ready_en0"}, 64'(ir), 64'(0));
        if (ov && ordy) begin
            qs = (id == 0) ? exp_q0.size() : exp_q1.size();
            check({px, "_out_expected"}, 64'(qs > 0), 64'(1));
            if (qs > 0) begin
                e = (id == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                check({px, "_code"}, code, e);
                if (id == 1) begin
                    es = syn_q1.pop_front();
                    if (es >= 0) begin
                        syn = 0;
                        for (int k = 1; k < cw; k++) if (code[k]) syn = syn ^ k;
                        check("b_syndrome", 64'(syn), 64'(es));
                    end
                end
            end
            m_cnt[id] = (m_cnt[id] + 1) % 65536;
        end
        acc = iv && ir;
        if (acc) begin
            acc_f[id] = 1'b1;
            pushed[id]++;
            e  = ref_code(dw, data);
            es = 0;
            if (m_armed[id] || ireq) begin
                p  = m_armed[id] ? m_pos[id] : ipos;
                d  = m_armed[id] ? m_dbl[id] : idbl;
                e  = e ^ flip_msk(cw, p, d);
                if (p < cw) es = d ? -1 : p;
            end
            if (id == 0) exp_q0.push_back(e);
            else begin
                exp_q1.push_back(e);
                syn_q1.push_back(es);
            end
        end
        if (ireq && !(acc && !m_armed[id])) begin
            m_armed[id] = 1'b1;
            m_pos[id]   = ipos;
            m_dbl[id]   = idbl;
        end else if (acc) begin
            m_armed[id] = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        mon(0, 8, 4, a_out_valid, a_out_ready, 64'(a_code), a_in_valid, a_in_ready, a_en,
            64'(a_data), a_inj_req, int'(a_inj_pos), a_inj_dbl, a_inj_armed, a_word_cnt);
        mon(1, 22, 16, b_out_valid, b_out_ready, 64'(b_code), b_in_valid, b_in_ready, b_en,
            64'(b_data), b_inj_req, int'(b_inj_pos), b_inj_dbl, b_inj_armed, b_word_cnt);
    end

    // Presents one word on instance a and returns just before the accepting edge.
    task automatic send_a(input logic [3:0] d, input logic req, input int pos, input logic dbl);
        int k;
        @(posedge clk); #1;
        a_in_valid = 1'b1;
        a_data     = d;
        a_inj_req  = req;
        a_inj_pos  = 3'(pos);
        a_inj_dbl  = dbl;
        k = 0;
        @(negedge clk); #1;
        while (!acc_f[0] && k < 50) begin
            @(posedge clk); #1;
            a_inj_req = 1'b0;
            @(negedge clk); #1;
            k++;
        end
        check("a_accept_timeout", 64'(acc_f[0]), 64'(1));
    endtask

    task automatic one_word(input string tag, input logic [3:0] d, input logic req,
                            input int pos, input logic dbl, input logic [7:0] exp);
        int lat;
        send_a(d, req, pos, dbl);
        lat = 0;
        while (lat < 20) begin
            @(posedge clk); #1;
            if (lat == 0) begin
                a_in_valid = 1'b0;
                a_inj_req  = 1'b0;
            end
            lat++;
            if (a_out_valid) break;
        end
        check({tag, "_latency"}, 64'(lat), 64'(2));
        check({tag, "_code"}, 64'(a_code), 64'(exp));
        check({tag, "_armed"}, 64'(a_inj_armed), 64'(0));
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int t0, t1, seen, guard;
        a_en = 1'b1; a_in_valid = 1'b0; a_out_ready = 1'b0; a_data = '0;
        a_inj_req = 1'b0; a_inj_pos = '0; a_inj_dbl = 1'b0;
        b_en = 1'b1; b_in_valid = 1'b0; b_out_ready = 1'b0; b_data = '0;
        b_inj_req = 1'b0; b_inj_pos = '0; b_inj_dbl = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("a_reset_out_valid", 64'(a_out_valid), 64'(0));
        check("a_reset_in_ready", 64'(a_in_ready), 64'(0));
        check("a_reset_code", 64'(a_code), 64'(0));
        check("b_reset_code", 64'(b_code), 64'(0));
        rst_n       = 1'b1;
        a_out_ready = 1'b1;

        one_word("enc_b", 4'hB, 1'b0, 0, 1'b0, 8'hAA);
        one_word("enc_0", 4'h0, 1'b0, 0, 1'b0, 8'h00);
        one_word("enc_f", 4'hF, 1'b0, 0, 1'b0, 8'hFF);
        one_word("inj_single", 4'hB, 1'b1, 3, 1'b0, 8'hA2);
        one_word("inj_double", 4'hB, 1'b1, 3, 1'b1, 8'hB2);
        one_word("after_inj", 4'hB, 1'b0, 0, 1'b0, 8'hAA);

        // Re-arm overwrites; en=0 must neither accept nor consume the injection.
        @(posedge clk); #1;
        a_inj_req = 1'b1; a_inj_pos = 3'd1; a_inj_dbl = 1'b1;
        @(posedge clk); #1;
        a_inj_pos = 3'd5; a_inj_dbl = 1'b0;
        @(posedge clk); #1;
        a_inj_req = 1'b0; a_en = 1'b0; a_in_valid = 1'b1; a_data = 4'h3;
        repeat (3) @(posedge clk);
        #1;
        check("en0_in_ready", 64'(a_in_ready), 64'(0));
        check("en0_armed_held", 64'(a_inj_armed), 64'(1));
        a_in_valid = 1'b0; a_en = 1'b1;
        one_word("overwrite", 4'hB, 1'b0, 0, 1'b0, 8'h8A);

        send_a(4'h1, 1'b0, 0, 1'b0);
        t0 = cyc;
        send_a(4'h2, 1'b0, 0, 1'b0);
        send_a(4'h3, 1'b0, 0, 1'b0);
        send_a(4'h4, 1'b0, 0, 1'b0);
        t1 = cyc;
        check("b2b_cycles", 64'(t1 - t0), 64'(3));
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        repeat (5) @(posedge clk);

        do_reset();
        fork
            begin
                for (int i = 0; i < 6; i++) send_a(4'(i * 3 + 1), 1'b0, 0, 1'b0);
                @(posedge clk); #1;
                a_in_valid = 1'b0;
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                a_out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                check("bp_in_ready_full", 64'(a_in_ready), 64'(0));
                a_out_ready = 1'b1;
            end
        join
        repeat (10) @(posedge clk);
        #1;
        check("bp_word_cnt", 64'(a_word_cnt), 64'(6));
        check("bp_queue_empty", 64'(exp_q0.size()), 64'(0));

        a_out_ready = 1'b0;
        send_a(4'h5, 1'b0, 0, 1'b0);
        send_a(4'h6, 1'b0, 0, 1'b0);
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        @(posedge clk); #1;
        check("inflight_valid", 64'(a_out_valid), 64'(1));
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(a_out_valid), 64'(0));
        check("midrst_word_cnt", 64'(a_word_cnt), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        a_out_ready = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (a_out_valid) seen++;
        end
        check("midrst_no_output", 64'(seen), 64'(0));

        guard = 0;
        while (guard < 60000) begin
            @(posedge clk); #1;
            guard++;
            if (pushed[1] >= 10000) break;
            if (!b_in_valid || acc_f[1]) begin
                b_in_valid = ($urandom_range(0, 3) != 0);
                b_data     = 16'($urandom);
            end
            b_out_ready = ($urandom_range(0, 9) < 7);
            b_en        = ($urandom_range(0, 9) != 0);
            b_inj_req   = !m_armed[1] && ($urandom_range(0, 15) == 0);
            b_inj_pos   = 5'($urandom_range(0, 31));
            b_inj_dbl   = ($urandom_range(0, 3) == 0);
        end
        b_in_valid  = 1'b0;
        b_inj_req   = 1'b0;
        b_out_ready = 1'b1;
        b_en        = 1'b1;
        check("rand_words_sent", 64'(pushed[1]), 64'(10000));
        guard = 0;
        while (exp_q1.size() != 0 && guard < 100) begin
            @(posedge clk);
            guard++;
        end
        @(negedge clk); #1;
        check("rand_drain", 64'(exp_q1.size()), 64'(0));
        check("rand_word_cnt", 64'(b_word_cnt), 64'(m_cnt[1]));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
